frame_buffer_scheduler: RTL and testbench
=========================================

// Module: frame_buffer_scheduler
// PURPOSE
//  Sequences the double-buffered DDR2 frame store between the Mandelbrot render path and the HDMI display path.
//  Tells the render side which buffer and base address to write, and the display side which buffer to read.
//  Swaps buffers only at a display end-of-frame, restarts rendering on parameter update, and guards renders with a watchdog.
//  Sits between the port0 (render) and port1 (display) DDR2 controllers; all inputs are synchronous to clk.
// PARAMETERS
//  ADDR_W        30          byte-address width of the DDR2 user ports
//  FRAME0_BASE   30'h0000000 byte base address of buffer 0
//  FRAME1_BASE   30'h0400000 byte base address of buffer 1
//  CNT_W         16          width of the frames_rendered counter
//  TIMEOUT_CYC   2**26       max cycles in RENDER before watchdog abort; 0 disables the watchdog
// PORTS
//  clk              in   1      system clock, all logic on rising edge
//  reset            in   1      synchronous, active-high reset
//  mem_calib_done   in   1      DDR2 calibration complete (level)
//  update           in   1      render-parameter change (single-cycle pulse)
//  frame_ready      in   1      render engine finished the current frame (pulse)
//  end_frame        in   1      display finished reading a frame (pulse)
//  start_render     out  1      one-cycle pulse: begin rendering into render_base
//  render_abort     out  1      one-cycle pulse: discard the in-progress render
//  render_sel       out  1      buffer index being written
//  render_base      out  ADDR_W base address of render_sel
//  display_sel      out  1      buffer index being read
//  display_base     out  ADDR_W base address of display_sel
//  display_valid    out  1      display buffer holds a complete frame
//  swap             out  1      one-cycle pulse on buffer exchange
//  frames_rendered  out  CNT_W  completed swaps; wraps modulo 2**CNT_W
//  timeout_err      out  1      sticky flag: watchdog fired; cleared only by reset
// BEHAVIOUR
//  Outputs are registered.
//  Reset values:
//   - state=CALIB, render_sel=0, display_sel=1, display_valid=0
//   - start_render=0, render_abort=0, swap=0, frames_rendered=0, timeout_err=0
//   - render_base=FRAME0_BASE, display_base=FRAME1_BASE
//  Base addresses:
//   - render_base and display_base update in the same cycle as their selectors.
//   - Each equals FRAME1_BASE when its selector is 1, otherwise FRAME0_BASE.
//  States:
//   CALIB: wait for mem_calib_done=1.
//    - Then pulse start_render in the next cycle and go to RENDER.
//   RENDER: the watchdog counter runs.
//    - update=1: render_abort pulse, start_render pulse the cycle after, stay in RENDER, counter cleared.
//    - frame_ready=1 (and update=0): go to WAIT_SWAP.
//    - update and frame_ready in the same cycle: update wins and the frame is discarded.
//    - Counter reaches TIMEOUT_CYC: timeout_err<=1, render_abort pulse, restart as on update.
//   WAIT_SWAP: the render buffer is complete.
//    - display_valid=0: go to SWAP next cycle without waiting for end_frame.
//    - end_frame=1: go to SWAP.
//    - update=1 (priority over end_frame): start_render pulse, go to RENDER, frame discarded.
//   SWAP: one cycle.
//    - Invert render_sel/display_sel; set display_valid=1; pulse swap.
//    - frames_rendered+=1; pulse start_render; go to RENDER.
//  Calibration loss:
//   - mem_calib_done=0 in any state forces CALIB next cycle.
//   - render_abort pulses if leaving RENDER; display_valid<=0; selectors are held.
//  Pulse rules:
//   - start_render and render_abort are never high in the same cycle.
//   - start_render is never issued while mem_calib_done=0.
//   - end_frame outside WAIT_SWAP is ignored; frame_ready outside RENDER is ignored.
//  Latency:
//   - frame_ready to swap: 2 cycles when end_frame is already present or display_valid=0.
//   - swap and start_render are coincident.
// STRUCTURE
//  Shared header frame_defs.vh holds:
//   - state encodings (CALIB, RENDER, WAIT_SWAP, SWAP)
//   - FRAME0_BASE/FRAME1_BASE defaults, shared with the port0/port1 controllers
//  Sub-module render_watchdog (clk, reset, clear, run -> expired):
//   - expired is a one-cycle pulse; it is held off when TIMEOUT_CYC=0.
//  The top level holds the FSM, selector/base registers and frames_rendered.
// TESTING
//  1 Reset, then mem_calib_done=1 at cycle 5 -> start_render pulse at cycle 6, render_sel=0, render_base=0, display_valid=0.
//  2 First frame: frame_ready at cycle 20 with display_valid=0 -> swap at 22, render_sel=1, display_sel=0, display_valid=1, frames_rendered=1.
//  3 Second frame_ready, end_frame 100 cycles later -> no swap until end_frame; swap 1 cycle after end_frame; frames_rendered=2.
//  4 update coincident with frame_ready -> render_abort pulse, start_render next cycle, no swap, frames_rendered unchanged.
//  5 TIMEOUT_CYC=50, no frame_ready -> render_abort at cycle 50 of RENDER, timeout_err=1 and sticky through later swaps.
//  6 mem_calib_done drop mid-RENDER -> render_abort, state CALIB, display_valid=0; regain -> start_render into unchanged render_sel.

Source files
------------

// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared definitions for the frame buffer scheduler.
//  - sched_state_t : scheduler FSM states
//  - FRAME0_BASE_DEF / FRAME1_BASE_DEF : default byte bases of the two frame
//    buffers. The port0/port1 DDR2 controllers use the same values.
//  - wd_count_width() : counter width needed by the render watchdog
package frame_buffer_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_CALIB     = 2'd0,
    ST_RENDER    = 2'd1,
    ST_WAIT_SWAP = 2'd2,
    ST_SWAP      = 2'd3
  } sched_state_t;

  localparam int unsigned FB_ADDR_W_DEF   = 30;
  localparam logic [29:0] FRAME0_BASE_DEF = 30'h0000000;
  localparam logic [29:0] FRAME1_BASE_DEF = 30'h0400000;

  // The watchdog counter only has to reach timeout-1, so $clog2(timeout)
  // bits are enough; keep at least one bit for the degenerate settings.
  function automatic int unsigned wd_count_width(input int unsigned timeout);
    return (timeout > 32'd2) ? $clog2(timeout) : 32'd1;
  endfunction

endpackage

// File: rtl/frame_buffer_scheduler_render_watchdog.sv
// Render watchdog.
//  clk     : system clock
//  reset   : synchronous active-high reset
//  clear   : restart the count (render aborted / restarted)
//  run     : count this cycle (scheduler is rendering); low also clears
//  expired : high in the TIMEOUT_CYC-th consecutive running cycle since the
//            last clear; never asserted when TIMEOUT_CYC = 0
module frame_buffer_scheduler_render_watchdog
  import frame_buffer_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2**26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW        = wd_count_width(TIMEOUT_CYC);
  localparam int unsigned LIMIT     = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [CW-1:0] LIMIT_CNT = CW'(LIMIT);
  localparam bit ENABLE = (TIMEOUT_CYC != 0);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // The count saturates at the limit so it can never wrap back to zero and
  // miss an expiry if the owner does not clear it straight away.
  always_comb begin
    count_next = count_reg;
    if (clear || !run) begin
      count_next = '0;
    end else if (count_reg != LIMIT_CNT) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = ENABLE && run && (count_reg == LIMIT_CNT);

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Double-buffered DDR2 frame store sequencer between the Mandelbrot render
// path (port0) and the HDMI display path (port1).
//  clk, reset       : clock, synchronous active-high reset
//  mem_calib_done   : DDR2 calibration complete (level)
//  update           : render parameters changed (pulse)
//  frame_ready      : render engine finished its frame (pulse)
//  end_frame        : display finished reading a frame (pulse)
//  start_render     : pulse, begin rendering into render_base
//  render_abort     : pulse, discard the in-progress render
//  render_sel/base  : buffer being written and its byte base
//  display_sel/base : buffer being read and its byte base
//  display_valid    : display buffer holds a complete frame
//  swap             : pulse on buffer exchange
//  frames_rendered  : completed swaps, wraps
//  timeout_err      : sticky, watchdog has fired since reset
// All outputs are registered.
module frame_buffer_scheduler
  import frame_buffer_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] FRAME0_BASE = ADDR_W'(FRAME0_BASE_DEF),
  parameter logic [ADDR_W-1:0] FRAME1_BASE = ADDR_W'(FRAME1_BASE_DEF),
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TIMEOUT_CYC = 2**26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_calib_done,
  input  logic              update,
  input  logic              frame_ready,
  input  logic              end_frame,
  output logic              start_render,
  output logic              render_abort,
  output logic              render_sel,
  output logic [ADDR_W-1:0] render_base,
  output logic              display_sel,
  output logic [ADDR_W-1:0] display_base,
  output logic              display_valid,
  output logic              swap,
  output logic [CNT_W-1:0]  frames_rendered,
  output logic              timeout_err
);

  sched_state_t state_reg, state_next;
  // Set by an abort; the matching start_render goes out one cycle later so
  // abort and start never share a cycle.
  logic pending_reg, pending_next;
  logic start_reg, start_next;
  logic abort_reg, abort_next;
  logic swap_reg, swap_next;
  logic rsel_reg, rsel_next;
  logic dsel_reg, dsel_next;
  logic valid_reg, valid_next;
  logic terr_reg, terr_next;
  logic [CNT_W-1:0]  frames_reg, frames_next;
  logic [ADDR_W-1:0] rbase_reg, rbase_next;
  logic [ADDR_W-1:0] dbase_reg, dbase_next;
  logic wd_expired;

  frame_buffer_scheduler_render_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (abort_next),
    .run    (state_reg == ST_RENDER),
    .expired(wd_expired)
  );

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    start_next   = 1'b0;
    abort_next   = 1'b0;
    swap_next    = 1'b0;
    rsel_next    = rsel_reg;
    dsel_next    = dsel_reg;
    valid_next   = valid_reg;
    terr_next    = terr_reg;
    frames_next  = frames_reg;

    if (!mem_calib_done) begin
      // Losing calibration overrides everything; buffer roles are kept so
      // rendering resumes into the same buffer afterwards.
      state_next   = ST_CALIB;
      pending_next = 1'b0;
      valid_next   = 1'b0;
      abort_next   = (state_reg == ST_RENDER);
    end else begin
      case (state_reg)
        ST_CALIB: begin
          start_next = 1'b1;
          state_next = ST_RENDER;
        end
        ST_RENDER: begin
          if (update) begin
            abort_next   = 1'b1;
            pending_next = 1'b1;
          end else if (pending_reg) begin
            // frame_ready here cannot belong to the restarted render
            start_next   = 1'b1;
            pending_next = 1'b0;
          end else if (frame_ready) begin
            state_next = ST_WAIT_SWAP;
          end else if (wd_expired) begin
            abort_next   = 1'b1;
            pending_next = 1'b1;
            terr_next    = 1'b1;
          end
        end
        ST_WAIT_SWAP: begin
          if (update) begin
            start_next = 1'b1;
            state_next = ST_RENDER;
          end else if (end_frame || !valid_reg) begin
            // Exchange is made on entry so swap coincides with the new start.
            state_next  = ST_SWAP;
            rsel_next   = ~rsel_reg;
            dsel_next   = ~dsel_reg;
            valid_next  = 1'b1;
            swap_next   = 1'b1;
            start_next  = 1'b1;
            frames_next = frames_reg + 1'b1;
          end
        end
        ST_SWAP: begin
          state_next = ST_RENDER;
          // A parameter change on the swap cycle kills the render just begun.
          if (update) begin
            abort_next   = 1'b1;
            pending_next = 1'b1;
          end
        end
        default: state_next = ST_CALIB;
      endcase
    end

    rbase_next = rsel_next ? FRAME1_BASE : FRAME0_BASE;
    dbase_next = dsel_next ? FRAME1_BASE : FRAME0_BASE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_CALIB;
      pending_reg <= 1'b0;
      start_reg   <= 1'b0;
      abort_reg   <= 1'b0;
      swap_reg    <= 1'b0;
      rsel_reg    <= 1'b0;
      dsel_reg    <= 1'b1;
      valid_reg   <= 1'b0;
      terr_reg    <= 1'b0;
      frames_reg  <= '0;
      rbase_reg   <= FRAME0_BASE;
      dbase_reg   <= FRAME1_BASE;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      start_reg   <= start_next;
      abort_reg   <= abort_next;
      swap_reg    <= swap_next;
      rsel_reg    <= rsel_next;
      dsel_reg    <= dsel_next;
      valid_reg   <= valid_next;
      terr_reg    <= terr_next;
      frames_reg  <= frames_next;
      rbase_reg   <= rbase_next;
      dbase_reg   <= dbase_next;
    end
  end

  assign start_render    = start_reg;
  assign render_abort    = abort_reg;
  assign swap            = swap_reg;
  assign render_sel      = rsel_reg;
  assign display_sel     = dsel_reg;
  assign display_valid   = valid_reg;
  assign timeout_err     = terr_reg;
  assign frames_rendered = frames_reg;
  assign render_base     = rbase_reg;
  assign display_base    = dbase_reg;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Scoreboard bench for frame_buffer_scheduler: a reference model predicts
// every start_render / render_abort / swap pulse with the buffer state that
// accompanies it; a negedge monitor pops and compares whenever the DUT pulses.
module tb_frame_buffer_scheduler;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 50;
  localparam logic [29:0] F0 = 30'h0000000;
  localparam logic [29:0] F1 = 30'h0400000;

  logic clk = 1'b0;
  logic reset, mem_calib_done, update, frame_ready, end_frame;
  logic start_render, render_abort, render_sel, display_sel, display_valid, swap, timeout_err;
  logic [29:0] render_base, display_base;
  logic [CNT_W-1:0] frames_rendered;

  always #5 clk = ~clk;

  frame_buffer_scheduler #(
    .ADDR_W(30), .FRAME0_BASE(F0), .FRAME1_BASE(F1),
    .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done), .update(update),
    .frame_ready(frame_ready), .end_frame(end_frame), .start_render(start_render),
    .render_abort(render_abort), .render_sel(render_sel), .render_base(render_base),
    .display_sel(display_sel), .display_base(display_base), .display_valid(display_valid),
    .swap(swap), .frames_rendered(frames_rendered), .timeout_err(timeout_err)
  );

  typedef struct {
    int   cyc;
    logic start, abort, swp, rsel, dsel, valid, terr;
    logic [CNT_W-1:0] frames;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: what the render side is doing, in plain terms.
  localparam int M_IDLE = 0, M_RENDERING = 1, M_FRAME_DONE = 2, M_EXCHANGED = 3;
  int m_mode, m_frames, m_age;
  bit m_restart, m_rsel, m_dsel, m_valid, m_terr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_frames = 0; m_age = 0;
    m_restart = 0; m_rsel = 0; m_dsel = 1; m_valid = 0; m_terr = 0;
  endtask

  // m_age = cycles spent rendering since the last (re)start or abort
  task automatic model_step(input bit cal, input bit upd, input bit fr, input bit ef);
    bit st, ab, sw, timed;
    int age_now;
    exp_t e;
    st = 0; ab = 0; sw = 0;
    age_now = m_age + 1;
    timed = (age_now >= TIMEOUT);
    if (!cal) begin
      ab = (m_mode == M_RENDERING);
      m_mode = M_IDLE; m_valid = 0; m_restart = 0; m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin st = 1; m_mode = M_RENDERING; m_age = 0; end
        M_RENDERING: begin
          if (upd) begin ab = 1; m_restart = 1; m_age = 0; end
          else if (m_restart) begin st = 1; m_restart = 0; m_age = age_now; end
          else if (fr) begin m_mode = M_FRAME_DONE; m_age = 0; end
          else if (timed) begin ab = 1; m_restart = 1; m_terr = 1; m_age = 0; end
          else m_age = age_now;
        end
        M_FRAME_DONE: begin
          m_age = 0;
          if (upd) begin st = 1; m_mode = M_RENDERING; end
          else if (ef || !m_valid) begin
            sw = 1; st = 1; m_rsel = !m_rsel; m_dsel = !m_dsel;
            m_valid = 1; m_frames = m_frames + 1; m_mode = M_EXCHANGED;
          end
        end
        default: begin
          m_age = 0; m_mode = M_RENDERING;
          if (upd) begin ab = 1; m_restart = 1; end
        end
      endcase
    end
    cyc++;
    if (st || ab || sw) begin
      e.cyc = cyc; e.start = st; e.abort = ab; e.swp = sw;
      e.rsel = m_rsel; e.dsel = m_dsel; e.valid = m_valid; e.terr = m_terr;
      e.frames = m_frames[CNT_W-1:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic tick(input bit cal, input bit upd, input bit fr, input bit ef);
    mem_calib_done = cal; update = upd; frame_ready = fr; end_frame = ef;
    @(posedge clk);
    model_step(cal, upd, fr, ef);
    #1;
    update = 0; frame_ready = 0; end_frame = 0;
  endtask

  // Monitor: pops the scoreboard on every DUT pulse
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_pulse_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (start_render || render_abort || swap) begin
        check("start_abort_exclusive", start_render & render_abort, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_queue_size", 0, 1);
        end else if (exp_q[0].cyc != cyc) begin
          check("unexpected_pulse_cycle", cyc, exp_q[0].cyc);
        end else begin
          e = exp_q.pop_front();
          $display("cycle %0d: start=%0b abort=%0b swap=%0b rsel=%0b frames=%0d terr=%0b",
                   cyc, start_render, render_abort, swap, render_sel, frames_rendered, timeout_err);
          check("start_render", start_render, e.start);
          check("render_abort", render_abort, e.abort);
          check("swap", swap, e.swp);
          check("render_sel", render_sel, e.rsel);
          check("display_sel", display_sel, e.dsel);
          check("display_valid", display_valid, e.valid);
          check("frames_rendered", frames_rendered, e.frames);
          check("timeout_err", timeout_err, e.terr);
          check("render_base", render_base, e.rsel ? F1 : F0);
          check("display_base", display_base, e.dsel ? F1 : F0);
        end
      end
    end
  end

  initial begin
    int k, low_left;
    bit cal;
    reset = 1; mem_calib_done = 0; update = 0; frame_ready = 0; end_frame = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    cyc = 1;
    @(negedge clk);
    check("reset_start_render", start_render, 0);
    check("reset_render_abort", render_abort, 0);
    check("reset_swap", swap, 0);
    check("reset_render_sel", render_sel, 0);
    check("reset_display_sel", display_sel, 1);
    check("reset_render_base", render_base, F0);
    check("reset_display_base", display_base, F1);
    check("reset_display_valid", display_valid, 0);
    check("reset_frames", frames_rendered, 0);
    check("reset_timeout_err", timeout_err, 0);

    // 1: calibration arrives in cycle 5 -> start_render in cycle 6
    repeat (4) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    @(negedge clk);
    check("t1_start_render", start_render, 1);
    check("t1_render_sel", render_sel, 0);
    check("t1_render_base", render_base, F0);
    check("t1_display_valid", display_valid, 0);

    // 2: frame_ready with nothing on display -> swap two cycles later
    repeat (14) tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
    tick(1, 0, 0, 0);
    @(negedge clk);
    check("t2_swap", swap, 1);
    check("t2_render_sel", render_sel, 1);
    check("t2_display_sel", display_sel, 0);
    check("t2_display_valid", display_valid, 1);
    check("t2_frames", frames_rendered, 1);

    // 3: display busy -> hold until end_frame, swap one cycle after it
    repeat (10) tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
    repeat (100) tick(1, 0, 0, 0);
    @(negedge clk);
    check("t3_no_swap_yet", swap, 0);
    check("t3_frames_held", frames_rendered, 1);
    tick(1, 0, 0, 1);
    @(negedge clk);
    check("t3_swap", swap, 1);
    check("t3_frames", frames_rendered, 2);

    // 4: update together with frame_ready -> abort, restart, no swap
    repeat (6) tick(1, 0, 0, 0);
    tick(1, 1, 1, 0);
    @(negedge clk);
    check("t4_abort", render_abort, 1);
    check("t4_no_swap", swap, 0);
    tick(1, 0, 0, 0);
    @(negedge clk);
    check("t4_restart", start_render, 1);
    check("t4_frames", frames_rendered, 2);

    // 5: watchdog fires in the 50th render cycle counted from the abort
    k = 0;
    while (k < 200) begin
      k++;
      tick(1, 0, 0, 0);
      @(negedge clk);
      if (render_abort) break;
    end
    check("t5_watchdog_delay", k, 49);
    check("t5_timeout_err", timeout_err, 1);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
    tick(1, 0, 0, 1);
    @(negedge clk);
    check("t5_swap", swap, 1);
    check("t5_timeout_sticky", timeout_err, 1);
    check("t5_frames", frames_rendered, 3);

    // 6: calibration loss mid-render, then regain
    repeat (6) tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    @(negedge clk);
    check("t6_abort", render_abort, 1);
    check("t6_display_valid", display_valid, 0);
    repeat (3) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    @(negedge clk);
    check("t6_start_render", start_render, 1);
    check("t6_render_sel_kept", render_sel, 1);
    check("t6_render_base", render_base, F1);

    // Random traffic against the model
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left > 0) begin
        cal = 0; low_left--;
      end else begin
        cal = 1;
        if ($urandom_range(0, 299) == 0) low_left = $urandom_range(1, 6);
      end
      tick(cal, $urandom_range(0, 59) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 19) == 0);
    end
    repeat (3) tick(1, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
